// File: rtl/sync_cdc_hs_tx_pkg.sv
// Shared definitions for the req/ack CDC handshake pair (tx and rx sides).
package sync_cdc_hs_tx_pkg;

  localparam int unsigned C_SYNC_STAGES_DEF = 3;

  typedef enum logic [2:0] {
    ST_DRAIN   = 3'd0,
    ST_IDLE    = 3'd1,
    ST_LOAD    = 3'd2,
    ST_REQ     = 3'd3,
    ST_RELEASE = 3'd4
  } hs_state_e;

endpackage

// File: rtl/sync_cdc_bit.sv
// Multi-flop single-bit synchronizer for a level crossing into the clk domain.
module sync_cdc_bit #(
  parameter int unsigned C_STAGES = 3
) (
  input  logic clk,
  input  logic i_d,
  output logic o_q
);

  logic [C_STAGES-1:0] r_sync;

  // NOTE: synchronizer flops carry no reset; the consumer flushes them after reset instead.
  always_ff @(posedge clk) begin
    r_sync <= {r_sync[C_STAGES-2:0], i_d};
  end

  assign o_q = r_sync[C_STAGES-1];

endmodule

// File: rtl/sync_cdc_hs_tx.sv
// Source side of a four-phase req/ack CDC handshake: holds a word on the
// crossing bus, raises req, waits for the synchronized ack, then returns to zero.
module sync_cdc_hs_tx
  import sync_cdc_hs_tx_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH  = 32,
  parameter int unsigned C_SYNC_STAGES = C_SYNC_STAGES_DEF
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [C_DATA_WIDTH-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [C_DATA_WIDTH-1:0] cdc_data,
  output logic                    cdc_req,
  input  logic                    cdc_ack,
  output logic                    tx_done,
  output logic                    proto_err
);

  localparam int unsigned        C_CNT_W      = $clog2(C_SYNC_STAGES + 2);
  localparam logic [C_CNT_W-1:0] C_DRAIN_LAST = C_CNT_W'(C_SYNC_STAGES);

  hs_state_e               r_state;
  logic [C_CNT_W-1:0]      r_drain_cnt;
  logic [C_DATA_WIDTH-1:0] r_cdc_data;
  logic                    r_cdc_req;
  logic                    r_s_ready;
  logic                    r_tx_done;
  logic                    r_proto_err;
  logic                    w_ack_s;

  sync_cdc_bit #(
    .C_STAGES (C_SYNC_STAGES)
  ) u_ack_sync (
    .clk (clk),
    .i_d (cdc_ack),
    .o_q (w_ack_s)
  );

  // NOTE: all state updates use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= ST_DRAIN;
      r_drain_cnt <= '0;
      r_cdc_data  <= '0;
      r_cdc_req   <= 1'b0;
      r_s_ready   <= 1'b0;
      r_tx_done   <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;

      // An ack with no request outstanding is flagged but otherwise ignored.
      if (w_ack_s && (r_state == ST_IDLE || r_state == ST_LOAD)) begin
        r_proto_err <= 1'b1;
      end

      case (r_state)
        ST_DRAIN: begin
          // Require C_SYNC_STAGES+1 consecutive low acks before accepting work.
          if (w_ack_s) begin
            r_drain_cnt <= '0;
          end else if (r_drain_cnt == C_DRAIN_LAST) begin
            r_drain_cnt <= '0;
            r_s_ready   <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (s_valid && r_s_ready) begin
            r_cdc_data <= s_data;
            r_s_ready  <= 1'b0;
            r_state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_cdc_req <= 1'b1;
          r_state   <= ST_REQ;
        end
        ST_REQ: begin
          if (w_ack_s) begin
            r_cdc_req <= 1'b0;
            r_state   <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!w_ack_s) begin
            r_tx_done <= 1'b1;
            r_s_ready <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        // NOTE: unused encodings recover through DRAIN so the ack is re-flushed.
        default: begin
          r_state     <= ST_DRAIN;
          r_drain_cnt <= '0;
          r_cdc_req   <= 1'b0;
          r_s_ready   <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready   = r_s_ready;
  assign cdc_data  = r_cdc_data;
  assign cdc_req   = r_cdc_req;
  assign tx_done   = r_tx_done;
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_sync_cdc_hs_tx.sv
// Scoreboard bench for sync_cdc_hs_tx with a delayed-ack destination model.
module tb_sync_cdc_hs_tx;

  localparam int unsigned S       = 3;
  localparam int unsigned DW      = 32;
  localparam int unsigned ACK_DLY = 5;
  localparam int unsigned TMO     = 500;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] cdc_data;
  logic          cdc_req;
  logic          cdc_ack;
  logic          tx_done;
  logic          proto_err;

  logic          model_en = 1'b0;
  logic          ack_model = 1'b0;
  logic          ack_force = 1'b0;

  int            n_cmp = 0;
  int            n_err = 0;
  int            tx_cnt = 0;
  int            acc_cnt = 0;
  int            n_sent = 0;
  int            exp_done = 0;
  int            dly_cnt = 0;
  int            cyc = 0;
  int            acc_cyc = 0;
  logic          mon_prev_req = 1'b0;
  logic [DW-1:0] mon_prev_data = '0;
  logic [DW-1:0] mon_cur_word = '0;
  logic [DW-1:0] mon_exp = '0;
  logic [DW-1:0] sb_q[$];

  assign cdc_ack = model_en ? ack_model : ack_force;

  always #5 clk = ~clk;

  sync_cdc_hs_tx #(
    .C_DATA_WIDTH  (DW),
    .C_SYNC_STAGES (S)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .cdc_data  (cdc_data),
    .cdc_req   (cdc_req),
    .cdc_ack   (cdc_ack),
    .tx_done   (tx_done),
    .proto_err (proto_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] w, input bit hold);
    int n = 0;
    s_data  = w;
    s_valid = 1'b1;
    sb_q.push_back(w);
    n_sent++;
    while (!s_ready && n < TMO) begin
      tick();
      n++;
    end
    check("accept_tmo", 32'(n < TMO), 32'd1);
    tick();
    if (!hold) s_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (tx_cnt < target && n < TMO) begin
      tick();
      n++;
    end
    check("done_tmo", 32'(tx_cnt), 32'(target));
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!s_ready && n < 100) begin
      tick();
      n++;
      check("drain_quiet", 32'({cdc_req, tx_done}), 32'd0);
    end
  endtask

  initial begin
    int n;

    fork
      begin : dest_model
        forever begin
          @(negedge clk);
          if (!model_en) begin
            ack_model = 1'b0;
            dly_cnt   = 0;
          end else if (cdc_req != ack_model) begin
            dly_cnt++;
            if (dly_cnt >= int'(ACK_DLY)) begin
              ack_model = cdc_req;
              dly_cnt   = 0;
            end
          end else begin
            dly_cnt = 0;
          end
        end
      end
      begin : monitor
        forever begin
          @(negedge clk);
          cyc++;
          if (cdc_req && !mon_prev_req) begin
            if (sb_q.size() > 0) begin
              mon_exp = sb_q.pop_front();
              check("req_data", cdc_data, mon_exp);
              check("data_setup", mon_prev_data, mon_exp);
              mon_cur_word = mon_exp;
            end else begin
              check("sb_underflow", 32'(sb_q.size()), 32'd1);
            end
            check("ready_in_req", 32'(s_ready), 32'd0);
          end
          if (!cdc_req && mon_prev_req) check("ready_in_rel", 32'(s_ready), 32'd0);
          if (tx_done) begin
            tx_cnt++;
            check("done_data", cdc_data, mon_cur_word);
            check("done_latency", 32'(cyc - acc_cyc), 32'(2 * ACK_DLY + 2 * S + 2));
          end
          if (s_valid && s_ready) begin
            acc_cnt++;
            acc_cyc = cyc;
          end
          mon_prev_req  = cdc_req;
          mon_prev_data = cdc_data;
        end
      end
    join_none

    // Reset with a quiet ack, then the drain window.
    repeat (5) tick();
    check("rst_req", 32'(cdc_req), 32'd0);
    check("rst_data", cdc_data, 32'd0);
    check("rst_ready", 32'(s_ready), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_perr", 32'(proto_err), 32'd0);
    rstn = 1'b1;
    wait_ready(n);
    check("drain_len", 32'(n), 32'(S + 1));
    check("drain_perr", 32'(proto_err), 32'd0);

    // Single word through the delayed-ack destination.
    model_en = 1'b1;
    send(32'hDEAD_BEEF, 1'b0);
    exp_done++;
    wait_done(exp_done);
    repeat (4) tick();
    check("one_done", 32'(tx_cnt), 32'(exp_done));

    // Back-to-back words with s_valid held.
    send(32'h1, 1'b1);
    send(32'h2, 1'b1);
    send(32'h3, 1'b0);
    exp_done += 3;
    wait_done(exp_done);
    repeat (4) tick();
    check("b2b_done", 32'(tx_cnt), 32'(exp_done));
    check("b2b_accepts", 32'(acc_cnt), 32'(n_sent));

    // Spurious ack while idle.
    model_en = 1'b0;
    check("perr_pre", 32'(proto_err), 32'd0);
    ack_force = 1'b1;
    repeat (10) tick();
    ack_force = 1'b0;
    repeat (S + 2) tick();
    check("perr_set", 32'(proto_err), 32'd1);
    check("perr_ready", 32'(s_ready), 32'd1);
    model_en = 1'b1;
    send(32'h0000_00A5, 1'b0);
    exp_done++;
    wait_done(exp_done);
    check("perr_sticky", 32'(proto_err), 32'd1);

    // Reset while in REQ with the ack high.
    model_en = 1'b0;
    send(32'h0000_0077, 1'b0);
    n = 0;
    while (!cdc_req && n < int'(TMO)) begin
      tick();
      n++;
    end
    check("req_tmo", 32'(cdc_req), 32'd1);
    ack_force = 1'b1;
    tick();
    rstn = 1'b0;
    tick();
    check("mid_rst_req", 32'(cdc_req), 32'd0);
    check("mid_rst_ready", 32'(s_ready), 32'd0);
    rstn = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("stuck_ack_ready", 32'(s_ready), 32'd0);
    end
    ack_force = 1'b0;
    wait_ready(n);
    check("mid_rst_drain", 32'(n), 32'(2 * S + 1));
    check("perr_cleared", 32'(proto_err), 32'd0);

    // One-cycle ack glitch landing mid-drain.
    rstn = 1'b0;
    repeat (2) tick();
    ack_force = 1'b1;
    tick();
    rstn = 1'b1;
    ack_force = 1'b0;
    wait_ready(n);
    check("glitch_drain", 32'(n), 32'(2 * S + 1));

    // Normal operation after the glitch.
    model_en = 1'b1;
    send(32'h5A5A_0001, 1'b0);
    exp_done++;
    wait_done(exp_done);
    repeat (4) tick();

    check("total_done", 32'(tx_cnt), 32'(exp_done));
    check("total_accepts", 32'(acc_cnt), 32'(n_sent));
    check("sb_left", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
